// File: rtl/demux_lanes.sv
// Receive-side 1:4 byte lane de-striper: rebuilds lane A..D groups from the serial
// stream, pulses validOut per completed group, and counts partial groups lost to resync.
module demux_lanes #(
  parameter int WIDTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic              demuxCLK,
  input  logic              resetL,
  input  logic [WIDTH-1:0]  inputDemux,
  input  logic              validIn,
  input  logic              syncIn,
  output logic [WIDTH-1:0]  outputA,
  output logic [WIDTH-1:0]  outputB,
  output logic [WIDTH-1:0]  outputC,
  output logic [WIDTH-1:0]  outputD,
  output logic              validOut,
  output logic [1:0]        controlOutput,
  output logic [DROP_W-1:0] dropCount
);

  logic [WIDTH-1:0] stg_a_p0;
  logic [WIDTH-1:0] stg_b_p0;
  logic [WIDTH-1:0] stg_c_p0;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (&v) return v;
    return v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: stage lanes A..C; lane D completes the group into the output registers
  always_ff @(posedge demuxCLK or negedge resetL) begin
    if (!resetL) begin
      stg_a_p0      <= '0;
      stg_b_p0      <= '0;
      stg_c_p0      <= '0;
      outputA       <= '0;
      outputB       <= '0;
      outputC       <= '0;
      outputD       <= '0;
      validOut      <= 1'b0;
      controlOutput <= 2'd0;
      dropCount     <= '0;
    end else begin
      validOut <= 1'b0;
      if (syncIn) begin
        // Resync overrides completion: a byte arriving with syncIn always starts a new group
        if (controlOutput != 2'd0) dropCount <= sat_inc(dropCount);
        if (validIn) begin
          stg_a_p0      <= inputDemux;
          controlOutput <= 2'd1;
        end else begin
          controlOutput <= 2'd0;
        end
      end else if (validIn) begin
        case (controlOutput)
          2'd0: stg_a_p0 <= inputDemux;
          2'd1: stg_b_p0 <= inputDemux;
          2'd2: stg_c_p0 <= inputDemux;
          default: begin
            outputA  <= stg_a_p0;
            outputB  <= stg_b_p0;
            outputC  <= stg_c_p0;
            outputD  <= inputDemux;
            validOut <= 1'b1;
          end
        endcase
        controlOutput <= controlOutput + 2'd1;
      end
    end
  end

endmodule

// File: doc/demux_lanes.md
Name: demux_lanes

Overview:
- Receive-side counterpart of the 4:1 byte lane multiplexer in the PHY datapath.
- Takes the single serialized byte stream and de-stripes it back into four parallel lane bytes (A, B, C, D), in round-robin order.
- Presents each completed four-byte group with a one-cycle valid pulse to the lane-side logic.
- Supports resynchronisation to lane A and counts partial groups that resync discards.

Parameters:
- WIDTH, 8, bit width of each lane byte and of the serial input.
- DROP_W, 8, width of the saturating dropped-group counter.

Ports:
- demuxCLK  input  1  single clock; all state updates on rising edge.
- resetL  input  1  asynchronous, active-low reset.
- inputDemux  input  WIDTH  serialized byte from the mux side.
- validIn  input  1  inputDemux carries a valid byte this cycle.
- syncIn  input  1  resync: next stored byte is lane A; partial group discarded.
- outputA  output  WIDTH  lane A byte of last completed group (registered).
- outputB  output  WIDTH  lane B byte of last completed group (registered).
- outputC  output  WIDTH  lane C byte of last completed group (registered).
- outputD  output  WIDTH  lane D byte of last completed group (registered).
- validOut  output  1  one-cycle pulse: outputA..D updated with a new group.
- controlOutput  output  2  lane index the next valid byte is written to (00=A … 11=D).
- dropCount  output  DROP_W  number of partial groups discarded by syncIn; saturates at all-ones.

Behaviour:
- Reset (resetL=0, asynchronous):
  - outputA..D = 0, validOut = 0, controlOutput = 00, dropCount = 0.
  - Internal staging registers A..C = 0.
  - Takes effect immediately, mid-group included; the partial group is lost and not counted.
- Lane pointer: controlOutput is a 2-bit counter. It advances by 1 mod 4 on each edge with validIn=1. It holds when validIn=0.
- Staging:
  - Valid byte at pointer 00/01/10 is written to staging A/B/C.
  - Valid byte at pointer 11 completes the group.
- Group completion, on the edge where pointer=11 and validIn=1:
  - outputA..C <= staging A..C; outputD <= inputDemux.
  - validOut <= 1 for exactly one cycle; pointer wraps to 00.
- Latency: validOut and new outputs are visible the cycle after the 4th byte is sampled.
- Back-to-back groups with validIn held high give one validOut pulse every 4 cycles.
- Between groups, outputA..D hold their last values and validOut = 0.
- validIn=0 gaps anywhere in a group stall the pointer. The group still completes correctly and no pulse is generated during the gap.
- syncIn=1, validIn=0:
  - Pointer <= 00.
  - If pointer was non-zero, dropCount increments (saturating).
  - Staging contents are don't-care.
  - Outputs unchanged, no validOut.
- syncIn=1, validIn=1 (simultaneous):
  - Sync wins: partial group discarded and counted as above if pointer ≠ 00.
  - inputDemux is stored as lane A; pointer <= 01.
  - No validOut, even if pointer was 11.
- syncIn with pointer=00: no drop count; otherwise it behaves the same as above.
- dropCount at all-ones: stays all-ones on further drops.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then the sequence FF, F0, 0F, 00 with validIn=1 on 4 consecutive edges -> one cycle later outputA=FF, B=F0, C=0F, D=00, validOut=1 for one cycle, controlOutput=00.
- Two groups back-to-back (FF,F0,0F,00 then 11,22,33,44) -> validOut pulses on cycles 5 and 9; second pulse outputs 11/22/33/44.
- Same group with validIn=0 for 3 cycles between bytes 2 and 3 -> controlOutput holds 10 during the gap; single validOut with FF/F0/0F/00.
- Send AA, BB, then syncIn=1 with validIn=1 on byte CC, then DD, EE, 77 -> dropCount=1; outputs CC/DD/EE/77; no validOut before the 4th post-sync byte.
- Drive resetL low asynchronously (between clock edges) after 3 bytes -> outputs, controlOutput and dropCount clear at once; after release, 4 new bytes produce a correct group.
- Force 300 partial-group syncs with DROP_W=8 -> dropCount saturates at FF.
